rysy_lsu: RTL
=============

Name: rysy_lsu

Overview:
Parametrised load/store unit between the rysy core datapath and the data bus. It is the successor to the current byte-select write and read-extract logic, which handles only naturally aligned, single-cycle, zero-wait accesses. The block adds a request/ack bus handshake with wait states, configurable bus width (32/64), and optional splitting of misaligned accesses into two bus transactions. It builds byte enables, places store data on the right byte lanes, and returns sign- or zero-extended load data.

Parameters:
DATA_W, 32, bus and register width in bits; legal values are 32 and 64. NB = DATA_W/8 bytes per bus word.
ADDR_W, 32, address width in bits.
SPLIT_MISALIGNED, 1, 1 = split a word-crossing access into two bus accesses; 0 = flag it with misalign_err and issue no bus access.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous, active-high reset
req  in  1  access request; sampled only in IDLE
we_in  in  1  1 = store, 0 = load
size  in  2  00 byte, 01 half, 10 word, 11 dword (dword legal only when DATA_W=64)
unsigned_ld  in  1  1 = zero-extend load result, 0 = sign-extend
addr_in  in  ADDR_W  byte address
wdata_in  in  DATA_W  store data, right-aligned
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
rdata_out  out  DATA_W  extended load result
misalign_err  out  1  one-cycle pulse (only when SPLIT_MISALIGNED=0)
bus_req  out  1  bus access valid
bus_we  out  1  bus write strobe
bus_addr  out  ADDR_W  word-aligned address (low log2(NB) bits = 0)
bus_be  out  NB  byte enables
bus_wdata  out  DATA_W  lane-aligned store data
bus_ack  in  1  access complete; ignored while bus_req=0
bus_rdata  in  DATA_W  read data; valid in the cycle bus_ack=1

Behaviour:
- Reset (asynchronous): state goes to IDLE. busy, done, misalign_err, bus_req, bus_we, bus_be, bus_addr, bus_wdata and rdata_out are all 0.
- Reset mid-access: bus_req drops immediately and the access is abandoned. No done pulse is generated, and the bus must tolerate the abandoned access.
- FSM states: IDLE, ACC1, ACC2, DONE.
- IDLE, req=1 on a clock edge:
  - Latch we_in, size, unsigned_ld, addr_in and wdata_in.
  - Compute off = addr[log2(NB)-1:0] and nbytes = 1<<size.
  - If off+nbytes <= NB: single access, go to ACC1.
  - Else if SPLIT_MISALIGNED=1: split access, go to ACC1 and then ACC2.
  - Else: pulse misalign_err in the next cycle, stay in IDLE, no bus activity.
- req in any state other than IDLE is ignored. The core must wait for busy=0.
- ACC1 drives:
  - bus_req=1, bus_we = latched we
  - bus_addr = addr with the low bits cleared
  - bus_be = ((1<<nbytes)-1) << off, truncated to NB bits
  - bus_wdata = wdata << 8*off
- ACC1 transitions: stay while bus_ack=0, with all bus outputs held stable. On bus_ack, capture the load bytes and go to ACC2 (split) or DONE.
- ACC2 drives:
  - bus_addr = first address + NB, modulo 2^ADDR_W (wraps)
  - bus_be = ((1<<nbytes)-1) >> (NB-off)
  - bus_wdata = wdata >> 8*(NB-off)
- ACC2 transitions: on bus_ack, go to DONE.
- Load assembly: bytes from ACC1 (starting at lane off) form the low part of the result; bytes from ACC2 lanes 0.. fill the upper part. The value is then sign- or zero-extended from nbytes to DATA_W.
- DONE: done=1 for one cycle, bus_req=0, then go to IDLE.
- rdata_out is updated on entry to DONE and held until the next completed load. Stores leave it unchanged.
- Latency: the request edge is E0. bus_req is high in the cycle after E0. With zero wait states, done is high 2 cycles after E0 for a single access and 3 cycles after E0 for a split access. Each wait cycle adds one cycle.
- size=11 when DATA_W=32 is treated as a word access.

Decomposition:
- Shared package: size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and FSM state encodings (ST_IDLE, ST_ACC1, ST_ACC2, ST_DONE).
- One natural combinational sub-module, rysy_lsu_align: byte-enable generation, lane shifting for both halves of a split, and load sign/zero extension. The FSM, latches and handshake stay in rysy_lsu.

Test Plan:
- Aligned store word: addr 0x100, wdata 0xDEADBEEF, ack at first opportunity. Required: one bus cycle with addr 0x100, be 1111, we=1, wdata 0xDEADBEEF; done 2 cycles after req.
- Signed load byte: addr 0x103, bus_rdata 0x80AABBCC. Required: be 1000, rdata_out 0xFFFFFF80. The same access with unsigned_ld=1 gives 0x00000080.
- Split load word: addr 0x102. First access addr 0x100, be 1100, rdata 0x2211AAAA. Second access addr 0x104, be 0011, rdata 0xBBBB4433. Required: rdata_out 0x44332211, done 3 cycles after req.
- Wrap: store word at 0xFFFFFFFE, wdata 0x44332211. Required: first access addr 0xFFFFFFFC, be 1100, wdata 0x22110000; second access addr 0x00000000, be 0011, wdata 0x00004433.
- SPLIT_MISALIGNED=0, load half at 0x103. Required: misalign_err pulses once, bus_req never asserted, done never asserted, busy stays 0.
- Wait states and reset: ack delayed 3 cycles, so bus_addr/be/wdata must stay stable and done must follow ack by 1 cycle. Then assert rst during ACC2 of a split access: bus_req must drop without waiting for a clock edge, no done; after release, an aligned load completes normally.

Source files
------------

// File: rtl/rysy_lsu_pkg.sv
// Shared encodings for the rysy load/store unit.
package rysy_lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ACC1 = 2'b01,
      ST_ACC2 = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   // A dword on a 32-bit bus degrades to a word.
   function automatic logic [3:0] size_bytes(input logic [1:0] s,
                                             input int dw);
      logic [3:0] n;
      n = 4'd4;
      unique case (s)
         SZ_B: n = 4'd1;
         SZ_H: n = 4'd2;
         SZ_W: n = 4'd4;
         SZ_D: n = (dw == 64) ? 4'd8 : 4'd4;
         default: n = 4'd4;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/rysy_lsu_align.sv
// Byte-lane steering for both halves of an access and load extension.
module rysy_lsu_align
   import rysy_lsu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]                  i_size,
   input  logic [$clog2(DATA_W/8)-1:0] i_off,
   input  logic                        i_unsigned,
   input  logic [DATA_W-1:0]           i_wdata,
   input  logic [DATA_W-1:0]           i_rd_lo,
   input  logic [DATA_W-1:0]           i_rd_hi,
   output logic [DATA_W/8-1:0]         o_be1,
   output logic [DATA_W/8-1:0]         o_be2,
   output logic [DATA_W-1:0]           o_wd1,
   output logic [DATA_W-1:0]           o_wd2,
   output logic [DATA_W-1:0]           o_ld
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = $clog2(DATA_W);

   logic [3:0]          w_nb;
   logic [2*NB-1:0]     w_mask;
   logic [2*NB-1:0]     w_be;
   logic [2*DATA_W-1:0] w_wd;
   logic [2*DATA_W-1:0] w_raw_all;
   logic [DATA_W-1:0]   w_raw;
   logic [IDX_W-1:0]    w_msb;
   logic                w_sign;

   assign w_nb = size_bytes(i_size, DATA_W);

   always_comb begin
      w_mask = '0;
      for (int i = 0; i < NB; i++) begin
         w_mask[i] = (i < int'(w_nb));
      end
   end

   // Double-width shifts: low half feeds ACC1, high half spills into ACC2.
   assign w_be  = w_mask << i_off;
   assign o_be1 = w_be[NB-1:0];
   assign o_be2 = w_be[2*NB-1:NB];

   assign w_wd  = {{DATA_W{1'b0}}, i_wdata} << {i_off, 3'b000};
   assign o_wd1 = w_wd[DATA_W-1:0];
   assign o_wd2 = w_wd[2*DATA_W-1:DATA_W];

   assign w_raw_all = {i_rd_hi, i_rd_lo} >> {i_off, 3'b000};
   assign w_raw     = w_raw_all[DATA_W-1:0];

   assign w_msb  = IDX_W'(8 * int'(w_nb) - 1);
   assign w_sign = ~i_unsigned & w_raw[w_msb];

   always_comb begin
      o_ld = w_raw;
      for (int i = 0; i < DATA_W; i++) begin
         if (i > int'(w_msb)) o_ld[i] = w_sign;
      end
   end

endmodule

// File: rtl/rysy_lsu.sv
// Load/store unit: request latch, bus handshake FSM and misalign split.
module rysy_lsu
   import rysy_lsu_pkg::*;
#(
   parameter int DATA_W           = 32,
   parameter int ADDR_W           = 32,
   parameter int SPLIT_MISALIGNED = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req,
   input  logic                we_in,
   input  logic [1:0]          size,
   input  logic                unsigned_ld,
   input  logic [ADDR_W-1:0]   addr_in,
   input  logic [DATA_W-1:0]   wdata_in,
   output logic                busy,
   output logic                done,
   output logic [DATA_W-1:0]   rdata_out,
   output logic                misalign_err,
   output logic                bus_req,
   output logic                bus_we,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W/8-1:0] bus_be,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic                bus_ack,
   input  logic [DATA_W-1:0]   bus_rdata
);

   localparam int NB    = DATA_W / 8;
   localparam int OFF_W = $clog2(NB);

   state_e              r_state;
   state_e              w_next;
   logic                r_we;
   logic                r_uns;
   logic                r_split;
   logic                r_mis;
   logic [1:0]          r_size;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rd1;
   logic [DATA_W-1:0]   r_rdata;

   logic [4:0]          w_req_end;
   logic                w_cross;
   logic                w_fin;
   logic [ADDR_W-1:0]   w_base;
   logic [NB-1:0]       w_be1;
   logic [NB-1:0]       w_be2;
   logic [DATA_W-1:0]   w_wd1;
   logic [DATA_W-1:0]   w_wd2;
   logic [DATA_W-1:0]   w_ld;
   logic [DATA_W-1:0]   w_rd_lo;
   logic [DATA_W-1:0]   w_rd_hi;

   assign w_req_end = 5'(addr_in[OFF_W-1:0])
                    + 5'(size_bytes(size, DATA_W));
   assign w_cross   = w_req_end > 5'(NB);
   assign w_base    = {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   // Split loads join ACC1 bytes (low) with the live ACC2 word (high).
   assign w_rd_lo = r_split ? r_rd1 : bus_rdata;
   assign w_rd_hi = r_split ? bus_rdata : '0;
   assign w_fin   = bus_ack
                 && ((r_state == ST_ACC1 && !r_split)
                  || r_state == ST_ACC2);

   assign misalign_err = r_mis;
   assign rdata_out    = r_rdata;

   rysy_lsu_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .i_size     (r_size),
      .i_off      (r_addr[OFF_W-1:0]),
      .i_unsigned (r_uns),
      .i_wdata    (r_wdata),
      .i_rd_lo    (w_rd_lo),
      .i_rd_hi    (w_rd_hi),
      .o_be1      (w_be1),
      .o_be2      (w_be2),
      .o_wd1      (w_wd1),
      .o_wd2      (w_wd2),
      .o_ld       (w_ld)
   );

   always_comb begin
      w_next    = r_state;
      busy      = (r_state != ST_IDLE);
      done      = 1'b0;
      bus_req   = 1'b0;
      bus_we    = 1'b0;
      bus_addr  = '0;
      bus_be    = '0;
      bus_wdata = '0;
      unique case (r_state)
         ST_IDLE: begin
            if (req && (!w_cross || SPLIT_MISALIGNED != 0))
               w_next = ST_ACC1;
         end
         ST_ACC1: begin
            bus_req   = 1'b1;
            bus_we    = r_we;
            bus_addr  = w_base;
            bus_be    = w_be1;
            bus_wdata = w_wd1;
            if (bus_ack)
               w_next = r_split ? ST_ACC2 : ST_DONE;
         end
         ST_ACC2: begin
            bus_req   = 1'b1;
            bus_we    = r_we;
            bus_addr  = w_base + ADDR_W'(NB);
            bus_be    = w_be2;
            bus_wdata = w_wd2;
            if (bus_ack) w_next = ST_DONE;
         end
         ST_DONE: begin
            done   = 1'b1;
            w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_we    <= 1'b0;
         r_uns   <= 1'b0;
         r_split <= 1'b0;
         r_mis   <= 1'b0;
         r_size  <= '0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_rd1   <= '0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         r_mis   <= (r_state == ST_IDLE) && req && w_cross
                 && (SPLIT_MISALIGNED == 0);
         if (r_state == ST_IDLE && req) begin
            r_we    <= we_in;
            r_uns   <= unsigned_ld;
            r_size  <= size;
            r_addr  <= addr_in;
            r_wdata <= wdata_in;
            r_split <= w_cross;
         end
         if (r_state == ST_ACC1 && bus_ack) r_rd1 <= bus_rdata;
         if (w_fin && !r_we) r_rdata <= w_ld;
      end
   end

endmodule
